// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit for the 8-bit processor: sequences fetch/decode/execute,
// drives datapath selects and ALU op, waits on memory ready and counts retired instructions.
module unidade_controle_multiciclo #(
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              opcode,
  input  logic                    zero,
  input  logic                    mem_pronta,
  output logic                    pc_escrita,
  output logic                    ir_escrita,
  output logic                    mem_leitura,
  output logic                    mem_escrita,
  output logic                    i_ou_d,
  output logic                    reg_escrita,
  output logic                    mem_para_reg,
  output logic                    ula_fonte_a,
  output logic [1:0]              ula_fonte_b,
  output logic                    fonte_pc,
  output logic [2:0]              sinal_ula,
  output logic [3:0]              estado,
  output logic [LARGURA_CONT-1:0] instr_concluidas
);

  typedef enum logic [3:0] {
    BUSCA       = 4'd0,
    DECODIFICA  = 4'd1,
    EXECUTA_R   = 4'd2,
    ESCRITA_R   = 4'd3,
    CALC_END    = 4'd4,
    LE_MEM      = 4'd5,
    ESCRITA_LW  = 4'd6,
    ESCREVE_MEM = 4'd7,
    DESVIO      = 4'd8
  } estado_t;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b100;

  localparam logic [LARGURA_CONT-1:0] UM = {{(LARGURA_CONT-1){1'b0}}, 1'b1};

  estado_t                 r_estado;
  estado_t                 w_prox;
  logic [LARGURA_CONT-1:0] r_cont;
  logic                    w_conclui;
  logic                    w_pc_escrita;
  logic                    w_ir_escrita;
  logic                    w_mem_leitura;
  logic                    w_mem_escrita;
  logic                    w_reg_escrita;

  // R-type opcode to ALU operation
  function automatic logic [2:0] f_ula_r(input logic [2:0] op);
    case (op)
      3'b000:  f_ula_r = ULA_ADD;
      3'b001:  f_ula_r = ULA_SUB;
      3'b010:  f_ula_r = ULA_AND;
      3'b011:  f_ula_r = ULA_OR;
      3'b100:  f_ula_r = ULA_SLT;
      default: f_ula_r = ULA_ADD;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= BUSCA;
      r_cont   <= '0;
    end else begin
      r_estado <= w_prox;
      if (w_conclui) r_cont <= r_cont + UM;
    end
  end

  always_comb begin
    w_prox        = BUSCA;
    w_conclui     = 1'b0;
    w_pc_escrita  = 1'b0;
    w_ir_escrita  = 1'b0;
    w_mem_leitura = 1'b0;
    w_mem_escrita = 1'b0;
    w_reg_escrita = 1'b0;
    i_ou_d        = 1'b0;
    mem_para_reg  = 1'b0;
    ula_fonte_a   = 1'b0;
    ula_fonte_b   = 2'b00;
    fonte_pc      = 1'b0;
    sinal_ula     = ULA_ADD;
    case (r_estado)
      BUSCA: begin
        w_mem_leitura = 1'b1;
        ula_fonte_b   = 2'b01;
        w_ir_escrita  = mem_pronta;
        w_pc_escrita  = mem_pronta;
        w_prox        = mem_pronta ? DECODIFICA : BUSCA;
      end
      DECODIFICA: begin
        ula_fonte_b = 2'b10;
        if (opcode <= 3'b100)      w_prox = EXECUTA_R;
        else if (opcode == 3'b111) w_prox = DESVIO;
        else                       w_prox = CALC_END;
      end
      EXECUTA_R: begin
        ula_fonte_a = 1'b1;
        sinal_ula   = f_ula_r(opcode);
        w_prox      = ESCRITA_R;
      end
      ESCRITA_R: begin
        w_reg_escrita = 1'b1;
        w_conclui     = 1'b1;
      end
      CALC_END: begin
        ula_fonte_a = 1'b1;
        ula_fonte_b = 2'b10;
        w_prox      = (opcode == 3'b101) ? LE_MEM : ESCREVE_MEM;
      end
      LE_MEM: begin
        w_mem_leitura = 1'b1;
        i_ou_d        = 1'b1;
        w_prox        = mem_pronta ? ESCRITA_LW : LE_MEM;
      end
      ESCRITA_LW: begin
        w_reg_escrita = 1'b1;
        mem_para_reg  = 1'b1;
        w_conclui     = 1'b1;
      end
      ESCREVE_MEM: begin
        w_mem_escrita = 1'b1;
        i_ou_d        = 1'b1;
        w_conclui     = mem_pronta;
        w_prox        = mem_pronta ? BUSCA : ESCREVE_MEM;
      end
      DESVIO: begin
        ula_fonte_a  = 1'b1;
        sinal_ula    = ULA_SUB;
        fonte_pc     = 1'b1;
        w_pc_escrita = zero;
        w_conclui    = 1'b1;
      end
      default: w_prox = BUSCA;
    endcase
  end

  // Reset suppresses every write/read strobe so an aborted instruction has no side effect
  assign pc_escrita       = w_pc_escrita  & ~reset;
  assign ir_escrita       = w_ir_escrita  & ~reset;
  assign mem_leitura      = w_mem_leitura & ~reset;
  assign mem_escrita      = w_mem_escrita & ~reset;
  assign reg_escrita      = w_reg_escrita & ~reset;
  assign estado           = r_estado;
  assign instr_concluidas = r_cont;

endmodule
